uart_tx_buf: RTL and testbench
==============================

# uart_tx_buf

Byte buffer and request sequencer that sits directly upstream of the UART transmitter. Accepts bytes from a producer through a write strobe, stores them in a synchronous FIFO, and feeds the transmitter one byte at a time. For each byte it issues a single-cycle request, holds the data stable for the whole frame, and waits for the end-of-frame pulse before releasing the next byte. Producers can burst up to DEPTH bytes without watching transmitter state.

## Interface
- DEPTH, 16, FIFO depth in bytes; power of two, 2..256
- ADDR_W, 4, log2(DEPTH)
- GAP_CYCLES, 16, idle clocks inserted between frames (used only with UART_TX_BUF_GAP_EN); 1..65535
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe; one byte per asserted cycle
- wr_data  in  8  byte to enqueue
- flush  in  1  synchronous FIFO clear
- full  out  1  FIFO holds DEPTH bytes
- empty  out  1  FIFO holds 0 bytes
- count  out  ADDR_W+1  FIFO occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse when a write is dropped
- idle  out  1  FIFO empty and sequencer in IDLE
- tx_data  out  8  byte presented to the transmitter
- tx_req  out  1  transmit request
- tx_busy  in  1  transmitter busy
- uart_tx_end  in  1  transmitter end-of-frame pulse (one cycle)

## Operation
- The FIFO is a register or RAM array with wr_ptr and rd_ptr of ADDR_W bits that wrap modulo DEPTH, plus a count register.
- A write is accepted when wr_en=1 and full=0. If wr_en=1 and full=1, the byte is dropped and overflow pulses on the next cycle. This holds even if a pop occurs in the same cycle.
- Simultaneous accepted write and pop: count is unchanged and both pointers advance.
- flush=1: pointers and count go to 0. A write in the same cycle is discarded and does not raise overflow. A pending pop in the same cycle is suppressed. flush does not affect tx_data or a frame in progress.
- States: IDLE, REQ, WAIT, and GAP (GAP only with the macro).
- IDLE: if empty=0 and flush=0, pop the head byte into the tx_data register and go to REQ. Otherwise stay.
- REQ: tx_req=1. If tx_busy=0, the transmitter accepts on this edge, so go to WAIT. If tx_busy=1, stay in REQ with tx_req held.
- WAIT: tx_req=0 and tx_data is held. On uart_tx_end=1, go to GAP if the macro is defined, otherwise to IDLE.
- GAP: a gap counter counts GAP_CYCLES clocks, then the block returns to IDLE.
- tx_data changes only on the IDLE->REQ edge, so it is stable for the entire frame. This is required because the transmitter samples it bit by bit.
- A uart_tx_end pulse outside WAIT is ignored.
- idle = empty & (state==IDLE).

## Timing
- Reset values: full=0, empty=1, count=0, overflow=0, idle=1, tx_data=8'h00, tx_req=0, state=IDLE, all pointers and counters 0.
- Write to flags: an accepted write at edge k updates count, empty and full after edge k (registered).
- Write into an empty idle block: wr_en at cycle 0, IDLE sees empty=0 at cycle 1 and pops, REQ with tx_req=1 at cycle 2, transmitter tx_busy=1 at cycle 3.
- tx_req is high for exactly one cycle whenever the transmitter is idle.
- Back-to-back frames without the macro: uart_tx_end at cycle n, IDLE at n+1, tx_req at n+2. That gives 2 clocks between frames on top of the stop bit.
- With the macro: GAP occupies cycles n+1..n+GAP_CYCLES, IDLE at n+GAP_CYCLES+1, tx_req one cycle later.
- Asynchronous reset mid-frame returns every output to its reset value immediately and discards FIFO contents. The transmitter is reset by the same rst_n.

## Configuration
- UART_TX_BUF_GAP_EN defined: the GAP state and a 16-bit gap counter are compiled in, and each frame is followed by GAP_CYCLES extra idle clocks before the next request.
- Undefined: there is no GAP state or counter, WAIT goes straight to IDLE, and GAP_CYCLES is ignored.

## Test plan
- Reset, then single write 8'hA5 with the transmitter at 115200 baud: tx_req high for 1 cycle at cycle 2; tx_data=8'hA5 held until uart_tx_end; serial line shows start, 1,0,1,0,0,1,0,1, stop; idle returns to 1.
- Burst of 16 writes 8'h00..8'h0F, then 17th write 8'hFF: full=1, overflow pulses once; bytes 00..0F are transmitted in order and 8'hFF is never sent; count falls 16..0.
- Write and pop in the same cycle with count=5: count stays 5 and pointers advance. Also fill the FIFO to wrap rd_ptr/wr_ptr past DEPTH-1: order is preserved.
- flush asserted during the second of 3 queued frames: the frame in progress completes with unchanged tx_data; no further tx_req; count=0, empty=1.
- tx_busy forced to 1 while in REQ for 10 cycles: tx_req stays high and the state stays REQ; on release, exactly one frame is sent.
- With UART_TX_BUF_GAP_EN and GAP_CYCLES=16: distance from uart_tx_end to the next tx_req is 18 clocks; without the macro it is 2 clocks.

Source files
------------

// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - byte FIFO and one-frame-at-a-time request sequencer in front of a UART transmitter
//
// Purpose:
//   Producers push bytes with a write strobe into a DEPTH-entry FIFO.
//   The sequencer pops one byte at a time, issues a single-cycle tx_req
//   (held while the transmitter reports busy), keeps tx_data frozen for
//   the whole frame, and releases the next byte only after uart_tx_end.
//
// Optional feature:
//   UART_TX_BUF_GAP_EN - when defined, a GAP state with a 16-bit counter
//   inserts GAP_CYCLES idle clocks after every frame. When undefined the
//   sequencer goes straight from WAIT to IDLE and GAP_CYCLES is unused.
//
// Parameters:
//   DEPTH       FIFO depth in bytes (power of two, 2..256)
//   ADDR_W      log2(DEPTH)
//   GAP_CYCLES  idle clocks between frames with UART_TX_BUF_GAP_EN (1..65535)
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   wr_en        write strobe, one byte per asserted cycle
//   wr_data      byte to enqueue
//   flush        synchronous FIFO clear (does not disturb a frame in flight)
//   full         FIFO holds DEPTH bytes
//   empty        FIFO holds 0 bytes
//   count        FIFO occupancy, 0..DEPTH
//   overflow     one-cycle pulse the cycle after a write was dropped
//   idle         FIFO empty and sequencer in IDLE
//   tx_data      byte presented to the transmitter
//   tx_req       transmit request
//   tx_busy      transmitter busy
//   uart_tx_end  transmitter end-of-frame pulse

module uart_tx_buf #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              idle,
    output logic [7:0]        tx_data,
    output logic              tx_req,
    input  logic              tx_busy,
    input  logic              uart_tx_end
);

`ifdef UART_TX_BUF_GAP_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_GAP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;
`endif

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    state_t            state;

    logic wr_ok;
    logic pop;

    // Flags come straight from the registered count, so they change only
    // after the edge that accepted the write or pop.
    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);
    assign count = cnt;
    assign idle  = empty && (state == S_IDLE);

    // A write during flush is discarded silently; a write while full is
    // dropped even if the sequencer pops in the same cycle.
    assign wr_ok = wr_en && !full && !flush;

    // The sequencer only pops from IDLE, and flush suppresses that pop.
    assign pop   = (state == S_IDLE) && !empty && !flush;

    // Storage array carries no reset: contents are meaningless once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full && !flush;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (wr_ok) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                // Simultaneous push and pop leaves the occupancy unchanged.
                case ({wr_ok, pop})
                    2'b10:   cnt <= cnt + CNT_ONE;
                    2'b01:   cnt <= cnt - CNT_ONE;
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Request sequencer
    // ------------------------------------------------------------------
`ifdef UART_TX_BUF_GAP_EN
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    logic [15:0] gap_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            tx_req  <= 1'b0;
            tx_data <= 8'h00;
`ifdef UART_TX_BUF_GAP_EN
            gap_cnt <= 16'h0000;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // tx_data is loaded only here, so it stays frozen while
                    // the transmitter shifts the frame out bit by bit.
                    if (pop) begin
                        tx_data <= mem[rd_ptr];
                        tx_req  <= 1'b1;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    // The transmitter takes the byte on the first edge it
                    // is not busy; until then the request stays asserted.
                    if (!tx_busy) begin
                        tx_req <= 1'b0;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (uart_tx_end) begin
`ifdef UART_TX_BUF_GAP_EN
                        gap_cnt <= 16'h0000;
                        state   <= S_GAP;
`else
                        state   <= S_IDLE;
`endif
                    end
                end
`ifdef UART_TX_BUF_GAP_EN
                S_GAP: begin
                    // Occupies exactly GAP_CYCLES clocks after the end pulse.
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'h0001;
                    end
                end
`endif
                default: begin
                    tx_req <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb/tb_uart_tx_buf.sv - self-checking bench for uart_tx_buf with queue model and transmitter emulator

module tb_uart_tx_buf;

    localparam int DEPTH      = 16;
    localparam int ADDR_W     = 4;
    localparam int BIT_CLKS   = 2;
    localparam int FRAME_CLKS = 10 * BIT_CLKS;
`ifdef UART_TX_BUF_GAP_EN
    localparam int G = 16;
`else
    localparam int G = 0;
`endif
    localparam int EXP_GAP = G + 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic              flush = 1'b0;
    logic              tx_busy = 1'b0;
    logic              uart_tx_end = 1'b0;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              idle;
    logic [7:0]        tx_data;
    logic              tx_req;

    uart_tx_buf #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .GAP_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .flush       (flush),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .idle        (idle),
        .tx_data     (tx_data),
        .tx_req      (tx_req),
        .tx_busy     (tx_busy),
        .uart_tx_end (uart_tx_end)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: byte queue plus frame bookkeeping in cycle numbers
    // ------------------------------------------------------------------
    logic [7:0] mq[$];
    bit         m_open = 1'b0;   // a byte has left the queue, its frame not yet ended
    bit         m_acc  = 1'b0;   // transmitter has taken that byte
    bit         m_ovf  = 1'b0;
    logic [7:0] m_data = 8'h00;
    int         m_ready = 0;     // first cycle a new byte may leave the queue
    bit         full_now;

    bit snap_req  = 1'b0;
    bit snap_busy = 1'b0;
    int ovf_pulses = 0;
    int last_end  = -1;
    int last_rise = -1;
    int last_gap  = -1;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
                m_open  = 1'b0;
                m_acc   = 1'b0;
                m_ovf   = 1'b0;
                m_data  = 8'h00;
                m_ready = 0;
            end
            chk("count",    32'(count),    32'(mq.size()));
            chk("empty",    32'(empty),    32'(mq.size() == 0));
            chk("full",     32'(full),     32'(mq.size() == DEPTH));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("tx_req",   32'(tx_req),   32'(m_open && !m_acc));
            chk("idle",     32'(idle),     32'(mq.size() == 0 && !m_open && cyc >= m_ready));
            chk("tx_data",  32'(tx_data),  32'(m_data));

            if (overflow) ovf_pulses++;
            if (uart_tx_end && rst_n) last_end = cyc;
            if (tx_req && !snap_req) begin
                if (last_end > last_rise) last_gap = cyc - last_end;
                last_rise = cyc;
            end
            snap_req  = tx_req;
            snap_busy = tx_busy;

            if (rst_n) begin
                full_now = (mq.size() == DEPTH);
                if (m_open && m_acc && uart_tx_end) begin
                    m_open  = 1'b0;
                    m_ready = cyc + 1 + G;
                end else if (m_open && !m_acc && !tx_busy) begin
                    m_acc = 1'b1;
                end else if (!m_open && cyc >= m_ready && mq.size() > 0 && !flush) begin
                    m_data = mq.pop_front();
                    m_open = 1'b1;
                    m_acc  = 1'b0;
                end
                m_ovf = wr_en && full_now && !flush;
                if (flush) mq.delete();
                else if (wr_en && !full_now) mq.push_back(wr_data);
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmitter emulator: samples tx_data once per bit, logs each frame
    // ------------------------------------------------------------------
    bit         hold_busy = 1'b0;
    bit         in_frame  = 1'b0;
    int         fc = 0;
    int         b;
    logic [9:0] fbits = '0;
    logic [9:0] last_bits = '0;
    logic [7:0] sent_log[$];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            uart_tx_end = 1'b0;
            if (!rst_n) begin
                in_frame = 1'b0;
                tx_busy  = 1'b0;
            end else if (in_frame) begin
                fc++;
                if (fc == FRAME_CLKS) begin
                    in_frame    = 1'b0;
                    tx_busy     = 1'b0;
                    uart_tx_end = 1'b1;
                    last_bits   = fbits;
                    sent_log.push_back(fbits[8:1]);
                    chk("frame_start_bit", 32'(fbits[0]), 32'd0);
                    chk("frame_stop_bit",  32'(fbits[9]), 32'd1);
                end else if (fc % BIT_CLKS == BIT_CLKS / 2) begin
                    b = fc / BIT_CLKS;
                    if (b == 0)      fbits[b] = 1'b0;
                    else if (b == 9) fbits[b] = 1'b1;
                    else             fbits[b] = tx_data[b-1];
                end
            end else if (snap_req && !snap_busy) begin
                in_frame = 1'b1;
                fc       = 0;
                fbits    = '0;
                tx_busy  = 1'b1;
            end else begin
                tx_busy = hold_busy;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic write_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_sent(input int n, input int budget);
        int k = 0;
        while (sent_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("wait_sent", 32'(sent_log.size()), 32'(n));
    endtask

    task automatic wait_busy(input int budget);
        int k = 0;
        while (!tx_busy && k < budget) begin
            tick();
            k++;
        end
        chk("wait_busy", 32'(tx_busy), 32'd1);
    endtask

    task automatic wait_end(input int budget);
        int k = 0;
        while (!uart_tx_end && k < budget) begin
            tick();
            k++;
        end
        chk("wait_end", 32'(uart_tx_end), 32'd1);
    endtask

    int w;
    int base;

    initial begin
        repeat (3) tick();
        chk("rst_idle",    32'(idle),    32'd1);
        chk("rst_empty",   32'(empty),   32'd1);
        chk("rst_count",   32'(count),   32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_tx_req",  32'(tx_req),  32'd0);
        rst_n = 1'b1;
        tick();

        // Single byte A5: request two cycles after the write, serial 0,10100101,1
        w = cyc;
        write_byte(8'hA5);
        wait_sent(1, 200);
        chk("a5_req_latency", 32'(last_rise - w), 32'd2);
        chk("a5_byte",        32'(sent_log[0]), 32'hA5);
        chk("a5_serial",      32'(last_bits), 32'({1'b1, 8'hA5, 1'b0}));
        repeat (3) tick();
        chk("a5_idle_back", 32'(idle), 32'd1);

        // Transmitter held busy: first byte parks in REQ, burst fills FIFO, FF dropped
        hold_busy = 1'b1;
        write_byte(8'h55);
        for (int i = 0; i < 16; i++) write_byte(8'(i));
        write_byte(8'hFF);
        chk("burst_full",  32'(full),  32'd1);
        chk("burst_count", 32'(count), 32'd16);
        repeat (10) tick();
        chk("held_tx_req", 32'(tx_req),     32'd1);
        chk("burst_ovf",   32'(ovf_pulses), 32'd1);
        hold_busy = 1'b0;
        wait_sent(18, 17 * 60);
        chk("held_byte", 32'(sent_log[1]), 32'h55);
        for (int i = 0; i < 16; i++) chk("burst_order", 32'(sent_log[2+i]), 32'(i));
        chk("frame_gap",   32'(last_gap),   32'(EXP_GAP));
        chk("drain_count", 32'(count),      32'd0);
        chk("ovf_once",    32'(ovf_pulses), 32'd1);

        // Write and pop in the same cycle with five bytes queued
        hold_busy = 1'b1;
        write_byte(8'h11);
        for (int i = 1; i <= 5; i++) write_byte(8'(8'h20 + i));
        chk("five_count", 32'(count), 32'd5);
        hold_busy = 1'b0;
        wait_end(200);
        tick();
        repeat (G) tick();
        write_byte(8'h26);
        @(negedge clk);
        chk("pushpop_count", 32'(count), 32'd5);
        wait_sent(25, 7 * 60);
        chk("pp_first", 32'(sent_log[18]), 32'h11);
        for (int i = 1; i <= 6; i++) chk("pp_order", 32'(sent_log[18+i]), 32'(8'h20 + i));

        // Flush during the second of three queued frames
        base = sent_log.size();
        write_byte(8'h31);
        write_byte(8'h32);
        write_byte(8'h33);
        wait_sent(base + 1, 100);
        wait_busy(100);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h44;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        repeat (FRAME_CLKS + G + 10) tick();
        chk("flush_sent",   32'(sent_log.size()),  32'(base + 2));
        chk("flush_first",  32'(sent_log[base]),   32'h31);
        chk("flush_second", 32'(sent_log[base+1]), 32'h32);
        chk("flush_count",  32'(count),  32'd0);
        chk("flush_empty",  32'(empty),  32'd1);
        chk("flush_tx_req", 32'(tx_req), 32'd0);
        chk("flush_ovf",    32'(ovf_pulses), 32'd1);

        // Asynchronous reset in the middle of a frame
        write_byte(8'h77);
        write_byte(8'h78);
        write_byte(8'h79);
        wait_busy(100);
        repeat (3) tick();
        base = sent_log.size();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_tx_req",  32'(tx_req),  32'd0);
        chk("arst_count",   32'(count),   32'd0);
        chk("arst_empty",   32'(empty),   32'd1);
        chk("arst_full",    32'(full),    32'd0);
        chk("arst_idle",    32'(idle),    32'd1);
        chk("arst_tx_data", 32'(tx_data), 32'h00);
        tick();
        tick();
        rst_n = 1'b1;
        write_byte(8'h5A);
        wait_sent(base + 1, 100);
        chk("post_rst_byte", 32'(sent_log[base]), 32'h5A);
        repeat (FRAME_CLKS + G + 5) tick();
        chk("post_rst_sent", 32'(sent_log.size()), 32'(base + 1));

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        n_bad++;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
